uart_slv: RTL and testbench

UART_SLV -- requirements
Module: uart_slv

---
 rtl/uart_slv_pkg.sv | 35 +++
 rtl/uart_slv_fifo.sv | 65 ++++++
 rtl/uart_slv.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_slv.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_slv_pkg.sv
// uart_slv_pkg
// Shared definitions for the uart_slv memory-mapped UART slave:
//   - register offsets within the 256-byte slave window (addr[7:0])
//   - bit positions inside the STATUS register
//   - TX and RX state machine encodings
package uart_slv_pkg;

    localparam logic [7:0] OFF_TXDATA  = 8'h00;
    localparam logic [7:0] OFF_STATUS  = 8'h04;
    localparam logic [7:0] OFF_BAUDDIV = 8'h08;
    localparam logic [7:0] OFF_RXDATA  = 8'h0C;

    localparam int ST_TX_FULL      = 0;
    localparam int ST_TX_EMPTY     = 1;
    localparam int ST_TX_BUSY      = 2;
    localparam int ST_RX_VALID     = 3;
    localparam int ST_RX_OVERRUN   = 4;
    localparam int ST_TX_DROP      = 5;
    localparam int ST_RX_FRAME_ERR = 6;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_slv_fifo.sv
// uart_slv_fifo
// Byte-wide transmit FIFO, DEPTH entries (power of two, >= 2).
// Ports:
//   clk, c_sys_rst  clock, synchronous active-high reset (empties the FIFO)
//   push, wdata     write request and byte; ignored when full unless popping
//   pop, rdata      read request; rdata shows the oldest entry combinationally
//   full, empty     occupancy flags
module uart_slv_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       c_sys_rst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO still lands when the same edge frees a slot.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: storage has no reset; contents are don't-care until written, and
    // resetting an array would turn it into a large bank of reset flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (c_sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are log2(DEPTH) bits, so wrap is natural overflow.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_slv.sv
// uart_slv
// Memory-mapped UART slave: 8N1 transmitter fed by a TX FIFO, optional
// receiver. Optional feature macro: UART_SLV_RX_EN (adds uart_rx_i and RX).
// Ports:
//   clk, c_sys_rst                  clock, synchronous active-high reset
//   ic0_c_axi_mst_wr_valid/_addr/_data/_strobe   single-cycle write request
//   ic0_c_axi_mst_rd_valid, ic0_axi_mst_rd_addr  single-cycle read request
//   ic0_c_axi_slv_rd_ready_3, ic0_axi_slv_rd_data_3  registered read response
//   uart_tx_o                       serial out, idle high
//   uart_rx_i                       serial in (UART_SLV_RX_EN only)
// Registers: 0x00 TXDATA, 0x04 STATUS (W1C bits 4..6), 0x08 BAUDDIV, 0x0C RXDATA.
module uart_slv #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_3000,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
    input  logic        clk,
    input  logic        c_sys_rst,
    input  logic        ic0_c_axi_mst_wr_valid,
    input  logic        ic0_c_axi_mst_rd_valid,
    input  logic [31:0] ic0_axi_mst_wr_addr,
    input  logic [31:0] ic0_axi_mst_wr_data,
    input  logic [3:0]  ic0_axi_mst_wr_strobe,
    input  logic [31:0] ic0_axi_mst_rd_addr,
    output logic        ic0_c_axi_slv_rd_ready_3,
    output logic [31:0] ic0_axi_slv_rd_data_3,
    output logic        uart_tx_o
`ifdef UART_SLV_RX_EN
    ,
    input  logic        uart_rx_i
`endif
);

    import uart_slv_pkg::*;

    logic        wr_hit, rd_hit, push, status_wr, baud_wr;
    logic [7:0]  wr_off, rd_off;
    logic [31:0] wr_data;
    logic [15:0] baud_div_q;
    logic        tx_drop_q;
    logic [7:0]  fifo_rdata;
    logic        fifo_full, fifo_empty, pop;
    logic        rx_valid, rx_overrun, rx_frame_err;
    logic [7:0]  rx_data;
    logic [31:0] status, rd_mux;
    logic        unused_bits;

    assign wr_data   = ic0_axi_mst_wr_data;
    assign wr_off    = ic0_axi_mst_wr_addr[7:0];
    assign rd_off    = ic0_axi_mst_rd_addr[7:0];
    assign wr_hit    = ic0_c_axi_mst_wr_valid && (ic0_axi_mst_wr_addr[31:8] == BASE_ADDR[31:8]);
    assign rd_hit    = ic0_c_axi_mst_rd_valid && (ic0_axi_mst_rd_addr[31:8] == BASE_ADDR[31:8]);
    assign push      = wr_hit && (wr_off == OFF_TXDATA) && ic0_axi_mst_wr_strobe[0];
    assign status_wr = wr_hit && (wr_off == OFF_STATUS) && ic0_axi_mst_wr_strobe[0];
    assign baud_wr   = wr_hit && (wr_off == OFF_BAUDDIV);
    assign unused_bits = &{1'b0, wr_data[31:16], ic0_axi_mst_wr_strobe[3:2]};

    uart_slv_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .c_sys_rst (c_sys_rst),
        .push      (push),
        .wdata     (wr_data[7:0]),
        .pop       (pop),
        .rdata     (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---------------- TX state machine ----------------
    tx_state_t   tx_state, tx_next;
    logic [15:0] baud_cnt, div_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt;
    logic        bit_end;

    assign bit_end = (baud_cnt == div_q);

    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        tx_next = tx_state;
        pop     = 1'b0;
        case (tx_state)
            TX_IDLE:  if (!fifo_empty) begin
                          tx_next = TX_START;
                          pop     = 1'b1;
                      end
            TX_START: if (bit_end) tx_next = TX_DATA;
            TX_DATA:  if (bit_end && (bit_cnt == 3'd7)) tx_next = TX_STOP;
            TX_STOP:  if (bit_end) begin
                          // Chain straight into the next frame: no idle gap.
                          if (!fifo_empty) begin
                              tx_next = TX_START;
                              pop     = 1'b1;
                          end else begin
                              tx_next = TX_IDLE;
                          end
                      end
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (c_sys_rst) begin
            tx_state <= TX_IDLE;
            baud_cnt <= '0;
            div_q    <= '0;
            shift_q  <= '0;
            bit_cnt  <= '0;
        end else begin
            tx_state <= tx_next;
            if (pop) begin
                // Divider is frozen per frame so BAUDDIV writes mid-frame are safe.
                div_q    <= baud_div_q;
                shift_q  <= fifo_rdata;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if (tx_state != TX_IDLE) begin
                if (bit_end) begin
                    baud_cnt <= '0;
                    if (tx_state == TX_DATA) begin
                        shift_q <= shift_q >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end else begin
                    baud_cnt <= baud_cnt + 16'd1;
                end
            end
        end
    end

    assign uart_tx_o = (tx_state == TX_START) ? 1'b0 :
                       (tx_state == TX_DATA)  ? shift_q[0] : 1'b1;

    // ---------------- Control registers ----------------
    always_ff @(posedge clk) begin
        if (c_sys_rst) begin
            baud_div_q <= BAUD_DIV_RST;
            tx_drop_q  <= 1'b0;
        end else begin
            if (baud_wr && ic0_axi_mst_wr_strobe[0]) baud_div_q[7:0]  <= wr_data[7:0];
            if (baud_wr && ic0_axi_mst_wr_strobe[1]) baud_div_q[15:8] <= wr_data[15:8];
            if (status_wr && wr_data[ST_TX_DROP]) tx_drop_q <= 1'b0;
            if (push && fifo_full && !pop)        tx_drop_q <= 1'b1;
        end
    end

`ifdef UART_SLV_RX_EN
    // ---------------- RX path ----------------
    rx_state_t   rx_state, rx_next;
    logic        rx_s1, rx_s2, rx_prev;
    logic [15:0] rx_cnt, rx_half;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_mid, rx_bit_end, rx_restart, rx_rd;

    assign rx_rd      = rd_hit && (rd_off == OFF_RXDATA);
    // (BAUDDIV+1)>>1 without a 17-bit intermediate.
    assign rx_half    = {1'b0, baud_div_q[15:1]} + {15'd0, baud_div_q[0]};
    assign rx_mid     = (rx_cnt == rx_half);
    assign rx_bit_end = (rx_cnt == baud_div_q);
    assign rx_restart = (rx_state == RX_IDLE) || ((rx_state == RX_START) && rx_mid) ||
                        ((rx_state != RX_START) && rx_bit_end);

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_s2) rx_next = RX_START;
            // Line back high at mid start bit: treat as a glitch.
            RX_START: if (rx_mid) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_end && (rx_bit == 3'd7)) rx_next = RX_STOP;
            RX_STOP:  if (rx_bit_end) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (c_sys_rst) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_prev      <= 1'b1;
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            // rx_s1 may go metastable; only rx_s2 onwards is used.
            rx_s1    <= uart_rx_i;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_next;
            rx_cnt   <= rx_restart ? '0 : rx_cnt + 16'd1;
            if ((rx_state == RX_DATA) && rx_bit_end) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
            if (status_wr && wr_data[ST_RX_OVERRUN])   rx_overrun   <= 1'b0;
            if (status_wr && wr_data[ST_RX_FRAME_ERR]) rx_frame_err <= 1'b0;
            if (rx_rd) rx_valid <= 1'b0;
            if ((rx_state == RX_STOP) && rx_bit_end) begin
                if (rx_s2) begin
                    rx_data  <= rx_shift;
                    rx_valid <= 1'b1;
                    if (rx_valid && !rx_rd) rx_overrun <= 1'b1;
                end else begin
                    rx_frame_err <= 1'b1;
                end
            end
        end
    end
`else
    assign rx_valid     = 1'b0;
    assign rx_overrun   = 1'b0;
    assign rx_frame_err = 1'b0;
    assign rx_data      = 8'h00;
`endif

    // ---------------- Read path ----------------
    always_comb begin
        status                  = '0;
        status[ST_TX_FULL]      = fifo_full;
        status[ST_TX_EMPTY]     = fifo_empty;
        status[ST_TX_BUSY]      = (tx_state != TX_IDLE);
        status[ST_RX_VALID]     = rx_valid;
        status[ST_RX_OVERRUN]   = rx_overrun;
        status[ST_TX_DROP]      = tx_drop_q;
        status[ST_RX_FRAME_ERR] = rx_frame_err;
        case (rd_off)
            OFF_STATUS:  rd_mux = status;
            OFF_BAUDDIV: rd_mux = {16'd0, baud_div_q};
            OFF_RXDATA:  rd_mux = {24'd0, rx_data};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (c_sys_rst) begin
            ic0_c_axi_slv_rd_ready_3 <= 1'b0;
            ic0_axi_slv_rd_data_3    <= '0;
        end else begin
            ic0_c_axi_slv_rd_ready_3 <= rd_hit;
            ic0_axi_slv_rd_data_3    <= rd_hit ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_uart_slv.sv
// tb_uart_slv
// Self-checking bench for uart_slv: bus register access, 8N1 frame shape,
// FIFO overflow/drop, reset mid-frame, randomized frames, and (with
// UART_SLV_RX_EN) the receive path. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_uart_slv;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int          DEPTH = 4;

    logic        clk;
    logic        c_sys_rst;
    logic        wr_valid, rd_valid;
    logic [31:0] wr_addr, wr_data, rd_addr;
    logic [3:0]  wr_strobe;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        uart_tx_o;
    logic        uart_rx_i;

    int checks = 0;
    int errors = 0;

    uart_slv #(
        .BASE_ADDR    (BASE),
        .FIFO_DEPTH   (DEPTH),
        .BAUD_DIV_RST (16'd434)
    ) dut (
        .clk                      (clk),
        .c_sys_rst                (c_sys_rst),
        .ic0_c_axi_mst_wr_valid   (wr_valid),
        .ic0_c_axi_mst_rd_valid   (rd_valid),
        .ic0_axi_mst_wr_addr      (wr_addr),
        .ic0_axi_mst_wr_data      (wr_data),
        .ic0_axi_mst_wr_strobe    (wr_strobe),
        .ic0_axi_mst_rd_addr      (rd_addr),
        .ic0_c_axi_slv_rd_ready_3 (rd_ready),
        .ic0_axi_slv_rd_data_3    (rd_data),
        .uart_tx_o                (uart_tx_o)
`ifdef UART_SLV_RX_EN
        ,
        .uart_rx_i                (uart_rx_i)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns on the next falling edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        wr_valid  = 1'b1;
        wr_addr   = addr;
        wr_data   = data;
        wr_strobe = strb;
        @(negedge clk);
        wr_valid  = 1'b0;
        wr_strobe = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic ready);
        rd_valid = 1'b1;
        rd_addr  = addr;
        @(negedge clk);
        rd_valid = 1'b0;
        ready    = rd_ready;
        data     = rd_data;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        r;
        bus_read(addr, d, r);
        check({tag, "_rdy"}, r, 1'b1);
        check(tag, d, exp);
    endtask

    task automatic wait_start(input int bound, input string tag);
        int i = 0;
        while (uart_tx_o !== 1'b0 && i < bound) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_start"}, uart_tx_o, 1'b0);
    endtask

    // Expects to be called in the first cycle of the start bit. Each of the
    // ten 8N1 bits must hold for d+1 cycles.
    task automatic capture_frame(input int d, input logic [7:0] b, input string tag);
        logic [9:0] exp_bits;
        logic [9:0] got_bits;
        int         mism = 0;
        exp_bits = {1'b1, b, 1'b0};
        got_bits = '0;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c <= d; c++) begin
                if (uart_tx_o !== exp_bits[k]) mism++;
                if (c == d / 2) got_bits[k] = uart_tx_o;
                @(negedge clk);
            end
        end
        check({tag, "_bits"}, got_bits, exp_bits);
        check({tag, "_shape"}, mism, 0);
    endtask

    task automatic line_quiet(input int n, input string tag);
        int lows = 0;
        repeat (n) begin
            if (uart_tx_o !== 1'b1) lows++;
            @(negedge clk);
        end
        check(tag, lows, 0);
    endtask

    task automatic push_burst(input logic [7:0] bytes[$]);
        foreach (bytes[i]) bus_write(BASE, {24'h0, bytes[i]}, 4'h1);
    endtask

    task automatic send_rx(input int d, input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rx_i = bits[k];
            repeat (d + 1) @(negedge clk);
        end
        uart_rx_i = 1'b1;
        repeat (d + 1) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        logic        r;
        logic [39:0] busy_v;
        logic [7:0]  burst[$];
        logic [7:0]  model_fifo[$];
        logic [7:0]  exp_tx[$];
        logic        tx_idle_m;

        c_sys_rst = 1'b1;
        wr_valid  = 1'b0;
        rd_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = '0;
        wr_strobe = '0;
        uart_rx_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", uart_tx_o, 1'b1);
        check("rst_rdy", rd_ready, 1'b0);
        check("rst_rdata", rd_data, 32'h0);
        c_sys_rst = 1'b0;

        // Register access and read-response timing.
        read_check("status_rst", BASE + 32'h04, 32'h0000_0002);
        @(negedge clk);
        check("rdy_one_cycle", rd_ready, 1'b0);
        check("rdata_idle_zero", rd_data, 32'h0);
        read_check("baud_rst", BASE + 32'h08, 32'd434);
        read_check("unmapped_off", BASE + 32'h10, 32'h0);
        read_check("txdata_reads0", BASE + 32'h00, 32'h0);
`ifndef UART_SLV_RX_EN
        read_check("rxdata_absent", BASE + 32'h0C, 32'h0);
`endif
        bus_read(32'h0000_4004, d, r);
        check("other_base_rdy", r, 1'b0);
        check("other_base_data", d, 32'h0);
        bus_write(BASE + 32'h08, 32'd3, 4'hF);
        read_check("baud_wr", BASE + 32'h08, 32'd3);
        bus_write(32'h0000_4008, 32'd9, 4'hF);
        read_check("baud_other_base", BASE + 32'h08, 32'd3);

        // Strobe without byte 0: no push.
        bus_write(BASE, 32'h0000_00AA, 4'b0010);
        line_quiet(8, "strobe_no_frame");
        read_check("strobe_status", BASE + 32'h04, 32'h0000_0002);

        // 0x55 frame with busy polled every cycle.
        bus_write(BASE, 32'h0000_0055, 4'h1);
        wait_start(8, "f55");
        busy_v = '0;
        fork
            capture_frame(3, 8'h55, "f55");
            begin
                rd_valid = 1'b1;
                rd_addr  = BASE + 32'h04;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    busy_v[i] = rd_ready & rd_data[2];
                end
                rd_valid = 1'b0;
            end
        join
        check("f55_busy", busy_v, {40{1'b1}});
        check("f55_idle_after", uart_tx_o, 1'b1);
        read_check("f55_status_after", BASE + 32'h04, 32'h0000_0002);

        // Six back-to-back pushes into an idle transmitter.
        burst = {};
        for (int i = 0; i < 6; i++) burst.push_back(8'($urandom_range(0, 255)));
        model_fifo = {};
        exp_tx     = {};
        tx_idle_m  = 1'b1;
        foreach (burst[i]) begin
            if (tx_idle_m && model_fifo.size() > 0) begin
                exp_tx.push_back(model_fifo.pop_front());
                tx_idle_m = 1'b0;
            end
            if (model_fifo.size() < DEPTH) model_fifo.push_back(burst[i]);
        end
        while (model_fifo.size() > 0) exp_tx.push_back(model_fifo.pop_front());
        fork
            push_burst(burst);
            begin
                wait_start(20, "ovf");
                foreach (exp_tx[i]) capture_frame(3, exp_tx[i], $sformatf("ovf%0d", i));
            end
        join
        line_quiet(60, "ovf_no_extra");
        read_check("ovf_drop_set", BASE + 32'h04, 32'h0000_0022);
        bus_write(BASE + 32'h04, 32'h0000_0020, 4'h1);
        read_check("ovf_drop_clr", BASE + 32'h04, 32'h0000_0002);

        // BAUDDIV rewritten mid-frame only affects the following frame.
        burst = {8'h3C, 8'hC3};
        fork
            begin
                push_burst(burst);
                repeat (10) @(negedge clk);
                bus_write(BASE + 32'h08, 32'd1, 4'hF);
            end
            begin
                wait_start(10, "div_hold");
                capture_frame(3, 8'h3C, "div_hold0");
                capture_frame(1, 8'hC3, "div_hold1");
            end
        join
        line_quiet(5, "div_hold_idle");

        // Reset in the middle of the data bits.
        bus_write(BASE + 32'h08, 32'd3, 4'hF);
        burst = {8'hF0, 8'h0F};
        fork
            push_burst(burst);
            wait_start(10, "rst_mid");
        join
        repeat (12) @(negedge clk);
        c_sys_rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", uart_tx_o, 1'b1);
        c_sys_rst = 1'b0;
        read_check("rst_mid_status", BASE + 32'h04, 32'h0000_0002);
        line_quiet(100, "rst_mid_quiet");
        read_check("rst_mid_baud", BASE + 32'h08, 32'd434);

        // Randomized bursts at random dividers.
        for (int it = 0; it < 6; it++) begin
            int dv;
            int n;
            dv = $urandom_range(0, 4);
            n  = $urandom_range(1, 3);
            bus_write(BASE + 32'h08, dv, 4'hF);
            burst = {};
            for (int i = 0; i < n; i++) burst.push_back(8'($urandom_range(0, 255)));
            fork
                push_burst(burst);
                begin
                    wait_start(10, $sformatf("rnd%0d", it));
                    foreach (burst[i]) capture_frame(dv, burst[i], $sformatf("rnd%0d_%0d", it, i));
                end
            join
            line_quiet(4, $sformatf("rnd%0d_idle", it));
            read_check($sformatf("rnd%0d_status", it), BASE + 32'h04, 32'h0000_0002);
        end

`ifdef UART_SLV_RX_EN
        begin
            logic [7:0] rb;
            bus_write(BASE + 32'h08, 32'd3, 4'hF);
            send_rx(3, 8'hA3, 1'b1);
            send_rx(3, 8'h5C, 1'b1);
            repeat (6) @(negedge clk);
            read_check("rx_ovr_status", BASE + 32'h04, 32'h0000_001A);
            read_check("rx_data_5c", BASE + 32'h0C, 32'h0000_005C);
            read_check("rx_valid_clr", BASE + 32'h04, 32'h0000_0012);
            bus_write(BASE + 32'h04, 32'h0000_0010, 4'h1);
            read_check("rx_ovr_clr", BASE + 32'h04, 32'h0000_0002);
            send_rx(3, 8'h77, 1'b0);
            repeat (6) @(negedge clk);
            read_check("rx_ferr_status", BASE + 32'h04, 32'h0000_0042);
            read_check("rx_ferr_kept", BASE + 32'h0C, 32'h0000_005C);
            rb = 8'($urandom_range(0, 255));
            send_rx(3, rb, 1'b1);
            repeat (6) @(negedge clk);
            read_check("rx_rnd_status", BASE + 32'h04, 32'h0000_004A);
            read_check("rx_rnd_data", BASE + 32'h0C, {24'h0, rb});
            bus_write(BASE + 32'h04, 32'h0000_0040, 4'h1);
            read_check("rx_ferr_clr", BASE + 32'h04, 32'h0000_0002);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
